// File: rtl/gba_io_pkg.sv
// Shared types and constants for the GBA I/O side of the memory path:
// arbiter FSM states, request owner encoding, default bus widths and the
// read data returned when a memory response never arrives.
package gba_io_pkg;

  localparam int DEF_ADDR_W = 26;
  localparam int DEF_DATA_W = 16;

  // Read data reported for a transaction abandoned by the response watchdog.
  localparam logic [15:0] TIMEOUT_RDATA = 16'hDEAD;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REQ,
    WAIT_RSP,
    DONE
  } arb_state_e;

  typedef enum logic {
    OWNER_CART = 1'b0,
    OWNER_USB  = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_grant.sv
// Grant selection between the cartridge and USB request sources.
// Cart has priority, but after MAX_CART_STREAK back-to-back cart grants
// taken while USB was waiting, USB gets the next slot so it cannot starve.
// MAX_CART_STREAK must be at least 1.
module arb_grant #(
  parameter int MAX_CART_STREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic cart_valid,
  input  logic usb_valid,
  output logic grant_cart,
  output logic grant_usb
);

  localparam int STREAK_W = $clog2(MAX_CART_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CART_STREAK);

  logic [STREAK_W-1:0] streak_reg;
  logic                usb_turn;

  assign usb_turn   = usb_valid && (streak_reg == STREAK_MAX);
  assign grant_cart = enable && cart_valid && !usb_turn;
  assign grant_usb  = enable && usb_valid && !grant_cart;

  // Count cart grants that made USB wait; any USB grant or uncontended cart grant resets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_reg <= '0;
    end else if (grant_usb) begin
      streak_reg <= '0;
    end else if (grant_cart) begin
      if (!usb_valid) begin
        streak_reg <= '0;
      end else if (streak_reg != STREAK_MAX) begin
        streak_reg <= streak_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cart_usb_arbiter.sv
// Single-outstanding arbiter between the cartridge bus and USB host front
// ends and the external memory controller. The winning raw address is shown
// to the frame-buffer mapper for exactly one LOOKUP cycle, the mapped address
// is registered, the memory request is issued and the completion is routed
// back to the originating source.
// Optional build macro CART_USB_ARBITER_TIMEOUT_EN adds a response watchdog
// (TIMEOUT_CYCLES, must be >= 2) and the sticky timeout_err output.
// Each source keeps its own read-data register, updated on its own completion.
module cart_usb_arbiter
  import gba_io_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int MAX_CART_STREAK = 4
`ifdef CART_USB_ARBITER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES  = 64
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cart_req_valid,
  output logic              cart_req_ready,
  input  logic [ADDR_W-1:0] cart_req_addr,
  input  logic              cart_req_we,
  input  logic [DATA_W-1:0] cart_req_wdata,
  output logic              cart_rsp_valid,
  output logic [DATA_W-1:0] cart_rsp_rdata,
  input  logic              usb_req_valid,
  output logic              usb_req_ready,
  input  logic [ADDR_W-1:0] usb_req_addr,
  input  logic              usb_req_we,
  input  logic [DATA_W-1:0] usb_req_wdata,
  output logic              usb_rsp_valid,
  output logic [DATA_W-1:0] usb_rsp_rdata,
  output logic [ADDR_W-1:0] mb_cart_usb_addr,
  output logic              mb_from_cart,
  output logic              mb_from_usb,
  input  logic [ADDR_W-1:0] mb_mem_addr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_we,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata
`ifdef CART_USB_ARBITER_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  arb_state_e        state_reg, state_next;
  owner_e            owner_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              we_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] cart_rdata_reg;
  logic [DATA_W-1:0] usb_rdata_reg;

  logic              grant_cart;
  logic              grant_usb;
  logic              rsp_load;
  logic [DATA_W-1:0] rsp_data;

`ifdef CART_USB_ARBITER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_count_reg;
  logic             tmo_hit;
`endif

  arb_grant #(
    .MAX_CART_STREAK(MAX_CART_STREAK)
  ) u_grant (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (state_reg == IDLE),
    .cart_valid(cart_req_valid),
    .usb_valid (usb_req_valid),
    .grant_cart(grant_cart),
    .grant_usb (grant_usb)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state, plus the read data to hand back when a transaction completes.
  always_comb begin
    state_next = state_reg;
    rsp_load   = 1'b0;
    rsp_data   = '0;
`ifdef CART_USB_ARBITER_TIMEOUT_EN
    tmo_hit    = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (grant_cart || grant_usb) begin
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        state_next = REQ;
      end
      REQ: begin
        if (mem_req_ready) begin
          if (we_reg) begin
            state_next = DONE;
            rsp_load   = 1'b1;
          end else begin
            state_next = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          state_next = DONE;
          rsp_load   = 1'b1;
          rsp_data   = mem_rsp_rdata;
        end
`ifdef CART_USB_ARBITER_TIMEOUT_EN
        else if (tmo_count_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_next = DONE;
          rsp_load   = 1'b1;
          rsp_data   = DATA_W'(TIMEOUT_RDATA);
          tmo_hit    = 1'b1;
        end
`endif
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the winning request, the mapped address and per-source read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg      <= OWNER_CART;
      addr_reg       <= '0;
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
      mem_addr_reg   <= '0;
      cart_rdata_reg <= '0;
      usb_rdata_reg  <= '0;
    end else begin
      if (grant_usb) begin
        owner_reg <= OWNER_USB;
        addr_reg  <= usb_req_addr;
        we_reg    <= usb_req_we;
        wdata_reg <= usb_req_wdata;
      end else if (grant_cart) begin
        owner_reg <= OWNER_CART;
        addr_reg  <= cart_req_addr;
        we_reg    <= cart_req_we;
        wdata_reg <= cart_req_wdata;
      end
      if (state_reg == LOOKUP) begin
        mem_addr_reg <= mb_mem_addr;
      end
      if (rsp_load) begin
        if (owner_reg == OWNER_USB) begin
          usb_rdata_reg <= rsp_data;
        end else begin
          cart_rdata_reg <= rsp_data;
        end
      end
    end
  end

`ifdef CART_USB_ARBITER_TIMEOUT_EN
  // Watchdog counts cycles spent in WAIT_RSP and restarts whenever we leave it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_count_reg <= '0;
    end else if (state_reg == WAIT_RSP) begin
      tmo_count_reg <= tmo_count_reg + 1'b1;
    end else begin
      tmo_count_reg <= '0;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else if (tmo_hit) begin
      timeout_err <= 1'b1;
    end
  end
`endif

  // Ready pulses are combinational grants; gated so reset forces them low.
  assign cart_req_ready   = grant_cart && rst_n;
  assign usb_req_ready    = grant_usb && rst_n;

  // The mapper rotates frames on flagged zero-offset addresses, so the flags
  // and address must be quiet in every cycle except LOOKUP.
  assign mb_cart_usb_addr = (state_reg == LOOKUP) ? addr_reg : '0;
  assign mb_from_cart     = (state_reg == LOOKUP) && (owner_reg == OWNER_CART);
  assign mb_from_usb      = (state_reg == LOOKUP) && (owner_reg == OWNER_USB);

  assign mem_req_valid    = (state_reg == REQ);
  assign mem_req_addr     = mem_addr_reg;
  assign mem_req_we       = we_reg;
  assign mem_req_wdata    = wdata_reg;

  assign cart_rsp_valid   = (state_reg == DONE) && (owner_reg == OWNER_CART);
  assign usb_rsp_valid    = (state_reg == DONE) && (owner_reg == OWNER_USB);
  assign cart_rsp_rdata   = cart_rdata_reg;
  assign usb_rsp_rdata    = usb_rdata_reg;

endmodule

// File: tb/tb_cart_usb_arbiter.sv
// Bench for cart_usb_arbiter: table of single transactions plus hand-written
// sequences (stray response, grant fairness, mid-transaction reset and, when
// CART_USB_ARBITER_TIMEOUT_EN is defined, the response watchdog).
// Expected memory requests and responses go into queues when a grant is seen
// and are popped by the memory model and the response monitor.
module tb_cart_usb_arbiter;

  localparam int AW = 26;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cart_req_valid, cart_req_ready, cart_req_we;
  logic [AW-1:0] cart_req_addr;
  logic [DW-1:0] cart_req_wdata;
  logic          cart_rsp_valid;
  logic [DW-1:0] cart_rsp_rdata;
  logic          usb_req_valid, usb_req_ready, usb_req_we;
  logic [AW-1:0] usb_req_addr;
  logic [DW-1:0] usb_req_wdata;
  logic          usb_rsp_valid;
  logic [DW-1:0] usb_rsp_rdata;
  logic [AW-1:0] mb_cart_usb_addr;
  logic          mb_from_cart, mb_from_usb;
  logic [AW-1:0] mb_mem_addr;
  logic          mem_req_valid, mem_req_ready, mem_req_we;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_rdata;
`ifdef CART_USB_ARBITER_TIMEOUT_EN
  logic          timeout_err;
`endif

  // memory / mapper model configuration
  logic [AW-1:0] cfg_map_off = '0;
  int            cfg_ready_delay = 0;
  int            cfg_rsp_delay = 0;
  logic [DW-1:0] cfg_rdata = '0;
  bit            cfg_no_rsp = 1'b0;
  logic          resp_v = 1'b0;
  logic          stray_v = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int n_lk_cart = 0;
  int n_lk_usb = 0;
  int n_rsp = 0;

  typedef struct {
    bit            is_usb;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] map_off;
    int            ready_delay;
    int            rsp_delay;
    logic [DW-1:0] rdata;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } mem_exp_t;

  typedef struct packed {
    logic          is_usb;
    logic [DW-1:0] rdata;
  } rsp_exp_t;

  mem_exp_t exp_mem[$];
  rsp_exp_t exp_rsp[$];
  vec_t     vecs[6];

  always #5 clk = ~clk;

  // Mapper model: offsets the flagged address; garbage when not flagged.
  assign mb_mem_addr   = (mb_from_cart || mb_from_usb) ? (mb_cart_usb_addr + cfg_map_off) : {AW{1'b1}};
  assign mem_rsp_valid = resp_v | stray_v;

  cart_usb_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cart_req_valid  (cart_req_valid),
    .cart_req_ready  (cart_req_ready),
    .cart_req_addr   (cart_req_addr),
    .cart_req_we     (cart_req_we),
    .cart_req_wdata  (cart_req_wdata),
    .cart_rsp_valid  (cart_rsp_valid),
    .cart_rsp_rdata  (cart_rsp_rdata),
    .usb_req_valid   (usb_req_valid),
    .usb_req_ready   (usb_req_ready),
    .usb_req_addr    (usb_req_addr),
    .usb_req_we      (usb_req_we),
    .usb_req_wdata   (usb_req_wdata),
    .usb_rsp_valid   (usb_rsp_valid),
    .usb_rsp_rdata   (usb_rsp_rdata),
    .mb_cart_usb_addr(mb_cart_usb_addr),
    .mb_from_cart    (mb_from_cart),
    .mb_from_usb     (mb_from_usb),
    .mb_mem_addr     (mb_mem_addr),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_req_we      (mem_req_we),
    .mem_req_wdata   (mem_req_wdata),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_rdata   (mem_rsp_rdata)
`ifdef CART_USB_ARBITER_TIMEOUT_EN
    ,
    .timeout_err     (timeout_err)
`endif
  );

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [127:0] all_outputs();
    return {cart_req_ready, cart_rsp_valid, cart_rsp_rdata,
            usb_req_ready, usb_rsp_valid, usb_rsp_rdata,
            mb_cart_usb_addr, mb_from_cart, mb_from_usb,
            mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata};
  endfunction

  // Memory controller model: checks each request against the queue, stalls
  // ready, then returns read data after the configured delay.
  initial begin
    mem_exp_t e;
    logic     we_seen;
    mem_req_ready = 1'b0;
    mem_rsp_rdata = 16'h5A5A;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req_valid && !mem_req_ready) begin
        if (exp_mem.size() == 0) begin
          chk("mem_req_unexpected", mem_req_valid, 1'b0);
        end else begin
          e = exp_mem.pop_front();
          chk("mem_req_fields", {mem_req_addr, mem_req_we, mem_req_wdata}, e);
          for (int i = 0; i < cfg_ready_delay; i++) begin
            @(negedge clk);
            chk("mem_req_stall_stable", {mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata}, {1'b1, e});
          end
        end
        we_seen = mem_req_we;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        if (!we_seen && !cfg_no_rsp) begin
          for (int i = 0; i < cfg_rsp_delay; i++) @(negedge clk);
          resp_v = 1'b1;
          mem_rsp_rdata = cfg_rdata;
          @(negedge clk);
          resp_v = 1'b0;
          mem_rsp_rdata = 16'h5A5A;
        end
      end
    end
  end

  // Response / lookup monitor.
  always @(negedge clk) begin
    rsp_exp_t r;
    if (rst_n) begin
      if (mb_from_cart) n_lk_cart++;
      if (mb_from_usb) n_lk_usb++;
      if (mb_from_cart || mb_from_usb)
        chk("mb_flags_exclusive", {mb_from_cart && mb_from_usb}, 1'b0);
      else
        chk("mb_addr_quiet", mb_cart_usb_addr, '0);
      if (cart_rsp_valid || usb_rsp_valid) begin
        n_rsp++;
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", {cart_rsp_valid, usb_rsp_valid}, 2'b00);
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_owner", {cart_rsp_valid, usb_rsp_valid}, r.is_usb ? 2'b01 : 2'b10);
          chk("rsp_rdata", r.is_usb ? usb_rsp_rdata : cart_rsp_rdata, r.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  task automatic set_src(input bit is_usb, input bit valid, input bit we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (is_usb) begin
      usb_req_valid = valid; usb_req_we = we; usb_req_addr = addr; usb_req_wdata = wdata;
    end else begin
      cart_req_valid = valid; cart_req_we = we; cart_req_addr = addr; cart_req_wdata = wdata;
    end
  endtask

  task automatic run_txn(input vec_t v, input bit tmo, input int idx);
    int            lat;
    int            exp_lat;
    int            lk_c0, lk_u0;
    bit            granted;
    bit            seen;
    logic [DW-1:0] exp_rd;
    exp_rd  = v.we ? 16'h0 : (tmo ? 16'hDEAD : v.rdata);
    exp_lat = v.we ? 3 + v.ready_delay
                   : (tmo ? 3 + v.ready_delay + 64 : 4 + v.ready_delay + v.rsp_delay);
    @(posedge clk); #1;
    cfg_ready_delay = v.ready_delay;
    cfg_rsp_delay   = v.rsp_delay;
    cfg_rdata       = v.rdata;
    cfg_no_rsp      = tmo;
    cfg_map_off     = v.map_off;
    lk_c0 = n_lk_cart;
    lk_u0 = n_lk_usb;
    set_src(v.is_usb, 1'b1, v.we, v.addr, v.wdata);
    granted = 1'b0;
    for (int i = 0; i < 50 && !granted; i++) begin
      @(negedge clk);
      if (v.is_usb ? usb_req_ready : cart_req_ready) granted = 1'b1;
    end
    chk($sformatf("txn%0d_grant", idx), granted, 1'b1);
    if (granted) begin
      exp_mem.push_back('{addr: v.addr + v.map_off, we: v.we, wdata: v.wdata});
      exp_rsp.push_back('{is_usb: v.is_usb, rdata: exp_rd});
    end
    @(posedge clk); #1;
    set_src(v.is_usb, 1'b0, 1'b0, '0, '0);
    lat = 1;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (v.is_usb ? usb_rsp_valid : cart_rsp_valid) seen = 1'b1;
      else lat++;
    end
    chk($sformatf("txn%0d_latency", idx), lat, exp_lat);
    chk($sformatf("txn%0d_lookups", idx), {n_lk_cart - lk_c0, n_lk_usb - lk_u0},
        v.is_usb ? {32'd0, 32'd1} : {32'd1, 32'd0});
    @(negedge clk);
    chk($sformatf("txn%0d_rsp_pulse_width", idx), v.is_usb ? usb_rsp_valid : cart_rsp_valid, 1'b0);
    chk($sformatf("txn%0d_rdata_hold", idx), v.is_usb ? usb_rsp_rdata : cart_rsp_rdata, exp_rd);
    $display("txn %0d: %s %s addr=0x%07h latency=%0d rdata=0x%04h",
             idx, v.is_usb ? "usb " : "cart", v.we ? "write" : "read ", v.addr, lat,
             v.is_usb ? usb_rsp_rdata : cart_rsp_rdata);
  endtask

  initial begin
    bit   exp_order[10];
    bit   got;
    int   ng;
    int   guard;
    int   n_rsp0;
    bit   granted;
    vec_t vt;

    vecs[0] = '{1'b0, 1'b0, 26'h0000100, 16'h0000, 26'h0000000, 0, 2, 16'hBEEF};
    vecs[1] = '{1'b1, 1'b1, 26'h1E00000, 16'h1234, 26'h0000010, 5, 0, 16'h0000};
    vecs[2] = '{1'b0, 1'b1, 26'h0000000, 16'hFFFF, 26'h0000200, 0, 0, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 26'h3FFFFFF, 16'h0000, 26'h0000001, 0, 0, 16'hA5A5};
    vecs[4] = '{1'b0, 1'b0, 26'h2AAAAAA, 16'h0000, 26'h0000005, 2, 3, 16'h0001};
    vecs[5] = '{1'b1, 1'b0, 26'h0000040, 16'h0000, 26'h0000000, 1, 1, 16'hFFFF};
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    set_src(1'b0, 1'b0, 1'b0, '0, '0);
    set_src(1'b1, 1'b0, 1'b0, '0, '0);
    #3;
    chk("reset_outputs", all_outputs(), '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_outputs", all_outputs(), '0);
`ifdef CART_USB_ARBITER_TIMEOUT_EN
    chk("reset_timeout_err", timeout_err, 1'b0);
`endif

    for (int k = 0; k < 6; k++) run_txn(vecs[k], 1'b0, k);

    // Stray memory response while idle must be ignored.
    @(posedge clk); #1;
    stray_v = 1'b1;
    @(posedge clk); #1;
    stray_v = 1'b0;
    n_rsp0 = n_rsp;
    repeat (5) @(negedge clk);
    chk("stray_no_rsp", n_rsp, n_rsp0);
    chk("stray_idle_outputs", {mem_req_valid, mb_from_cart, mb_from_usb}, 3'b000);
    run_txn(vecs[3], 1'b0, 6);

    // Both sources requesting continuously: C,C,C,C,U repeating.
    @(posedge clk); #1;
    cfg_ready_delay = 0;
    cfg_no_rsp = 1'b0;
    cfg_map_off = '0;
    set_src(1'b0, 1'b1, 1'b1, 26'h0000040, 16'hC0DE);
    set_src(1'b1, 1'b1, 1'b1, 26'h0000080, 16'h0B0B);
    ng = 0;
    guard = 0;
    while (ng < 10 && guard < 500) begin
      @(negedge clk);
      guard++;
      if (cart_req_ready || usb_req_ready) begin
        got = usb_req_ready;
        chk($sformatf("grant_order_%0d", ng), got, exp_order[ng]);
        if (got) begin
          exp_mem.push_back('{addr: 26'h0000080, we: 1'b1, wdata: 16'h0B0B});
          exp_rsp.push_back('{is_usb: 1'b1, rdata: 16'h0000});
        end else begin
          exp_mem.push_back('{addr: 26'h0000040, we: 1'b1, wdata: 16'hC0DE});
          exp_rsp.push_back('{is_usb: 1'b0, rdata: 16'h0000});
        end
        ng++;
        $display("grant %0d: %s", ng, got ? "usb" : "cart");
      end
    end
    chk("grant_sequence_count", ng, 10);
    @(posedge clk); #1;
    set_src(1'b0, 1'b0, 1'b0, '0, '0);
    set_src(1'b1, 1'b0, 1'b0, '0, '0);
    guard = 0;
    while (exp_rsp.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("grant_sequence_drained", exp_rsp.size(), 0);

    // Reset while waiting for a read response: transaction is dropped.
    @(posedge clk); #1;
    cfg_no_rsp = 1'b1;
    cfg_ready_delay = 0;
    cfg_map_off = 26'h0000011;
    set_src(1'b0, 1'b1, 1'b0, 26'h0000777, '0);
    granted = 1'b0;
    for (int i = 0; i < 50 && !granted; i++) begin
      @(negedge clk);
      if (cart_req_ready) granted = 1'b1;
    end
    chk("reset_txn_grant", granted, 1'b1);
    exp_mem.push_back('{addr: 26'h0000788, we: 1'b0, wdata: 16'h0000});
    @(posedge clk); #1;
    set_src(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    chk("pre_reset_mem_addr", mem_req_addr, 26'h0000788);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", all_outputs(), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_rsp0 = n_rsp;
    repeat (10) @(negedge clk);
    chk("reset_dropped_no_rsp", n_rsp, n_rsp0);
    $display("reset during WAIT_RSP: transaction dropped");
    run_txn(vecs[0], 1'b0, 7);

`ifdef CART_USB_ARBITER_TIMEOUT_EN
    vt = '{1'b0, 1'b0, 26'h0000123, 16'h0000, 26'h0000000, 0, 0, 16'hBEEF};
    run_txn(vt, 1'b1, 8);
    chk("timeout_err_set", timeout_err, 1'b1);
    @(posedge clk); #1;
    stray_v = 1'b1;
    @(posedge clk); #1;
    stray_v = 1'b0;
    n_rsp0 = n_rsp;
    repeat (5) @(negedge clk);
    chk("late_rsp_ignored", n_rsp, n_rsp0);
    chk("timeout_err_sticky", timeout_err, 1'b1);
    run_txn(vecs[2], 1'b0, 9);
    chk("timeout_err_sticky_after_txn", timeout_err, 1'b1);
`else
    vt = vecs[4];
    run_txn(vt, 1'b0, 8);
`endif

    repeat (3) @(negedge clk);
    chk("rsp_queue_empty", exp_rsp.size(), 0);
    chk("mem_queue_empty", exp_mem.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
